// File: rtl/sw_nto1_arb_pkg.sv
// sw_nto1_arb_pkg: shared NOC arbiter state type and round-robin pointer helper
package sw_nto1_arb_pkg;

    typedef enum logic {ARB, LOCK} arb_st_e;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx == n - 1) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/sw_nto1_arb_rr_pick.sv
// rr_pick: combinational round-robin picker, first requester at or after rr_ptr_i
module rr_pick #(
    parameter int IN_N = 8,
    parameter int IN_W = 3
) (
    input  logic [IN_N-1:0] req_i,
    input  logic [IN_W-1:0] rr_ptr_i,
    output logic [IN_W-1:0] gnt_o,
    output logic            any_req_o
);

    logic [IN_N-1:0] win;
    int unsigned     off;
    int unsigned     sum;

    // Rotating the doubled vector puts rr_ptr_i at bit 0, so the lowest set bit is the winner.
    always_comb begin
        win = IN_N'({req_i, req_i} >> rr_ptr_i);
        off = 0;
        for (int k = IN_N - 1; k >= 0; k--) if (win[k]) off = k;
        sum = 32'(rr_ptr_i) + off;
        gnt_o = IN_W'((sum >= IN_N) ? sum - IN_N : sum);
        any_req_o = |req_i;
    end

endmodule

// File: rtl/sw_nto1_arb.sv
// sw_nto1_arb: N-to-1 round-robin arbiter with packet lock and zero-latency grant mux
module sw_nto1_arb
    import sw_nto1_arb_pkg::*;
#(
    parameter int IN_N  = 8,
    parameter int IN_W  = 3,
    parameter int TAG_W = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [IN_N-1:0]            upreq_i,
    input  logic [IN_N-1:0][TAG_W-1:0] uptag_i,
    input  logic [IN_N-1:0]            uplast_i,
    output logic [IN_N-1:0]            uprdy_o,
    output logic                       dnreq_o,
    output logic [TAG_W-1:0]           dntag_o,
    output logic                       dnlast_o,
    output logic [IN_W-1:0]            dnsrc_o,
    input  logic                       dnrdy_i
);

    arb_st_e         state_q, state_d;
    logic [IN_W-1:0] rr_ptr_q, rr_ptr_d, lock_src_q, lock_src_d;
    logic [IN_W-1:0] gnt, rr_gnt;
    logic            any_req, xfer, last;

    rr_pick #(.IN_N(IN_N), .IN_W(IN_W)) u_pick (
        .req_i     (upreq_i),
        .rr_ptr_i  (rr_ptr_q),
        .gnt_o     (rr_gnt),
        .any_req_o (any_req)
    );

    // Gating with rst_n_i keeps uprdy_o low for the whole time reset is held.
    always_comb begin
        gnt = (state_q == LOCK) ? lock_src_q : rr_gnt;
        dnreq_o = rst_n_i && ((state_q == LOCK) ? upreq_i[lock_src_q] : any_req);
        xfer = dnreq_o && dnrdy_i;
        last = uplast_i[gnt];
        uprdy_o = xfer ? (IN_N'(1) << gnt) : '0;
        dntag_o = dnreq_o ? uptag_i[gnt] : '0;
        dnlast_o = dnreq_o && last;
        dnsrc_o = dnreq_o ? gnt : '0;
        state_d = xfer ? (last ? ARB : LOCK) : state_q;
        lock_src_d = (xfer && !last) ? gnt : lock_src_q;
        rr_ptr_d = (xfer && last) ? IN_W'(rr_next(32'(gnt), IN_N)) : rr_ptr_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ARB;
            rr_ptr_q   <= '0;
            lock_src_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_src_q <= lock_src_d;
        end
    end

endmodule

// File: tb/tb_sw_nto1_arb.sv
// tb_sw_nto1_arb: scoreboard bench for sw_nto1_arb (8-source and 5-source instances)
module tb_sw_nto1_arb;
    import sw_nto1_arb_pkg::*;

    localparam int N  = 8;
    localparam int W  = 3;
    localparam int TW = 4;
    localparam int N5 = 5;

    typedef struct packed {
        logic [W-1:0]  src;
        logic [TW-1:0] tag;
        logic          last;
    } beat_t;

    logic                clk_i = 1'b0;
    logic                rst_n_i = 1'b0;
    logic [N-1:0]        upreq_i = '0;
    logic [N-1:0]        uplast_i = '0;
    logic [N-1:0][TW-1:0] uptag_i = '0;
    logic [N-1:0]        uprdy_o;
    logic                dnreq_o, dnlast_o;
    logic                dnrdy_i = 1'b1;
    logic [TW-1:0]       dntag_o;
    logic [W-1:0]        dnsrc_o;

    logic [N5-1:0]        req5 = '0;
    logic [N5-1:0]        last5 = '0;
    logic [N5-1:0][TW-1:0] tag5 = '0;
    logic [N5-1:0]        rdy5;
    logic                 dnreq5, dnlast5;
    logic                 dnrdy5 = 1'b1;
    logic [TW-1:0]        dntag5;
    logic [W-1:0]         dnsrc5;

    logic [TW:0]   tab [N][8];
    int            len [N];
    int            ptr [N];
    logic [N-1:0]  hold, acc, pend;
    logic [TW-1:0] pend_tag [N];
    beat_t         expq [$];
    int            n_tests = 0;
    int            n_fail = 0;

    logic [N-1:0]  s_rdy;
    logic [N5-1:0] s5_rdy;
    logic          s_req, s_xfer;
    logic [W-1:0]  s_src, s5_src;
    logic [TW-1:0] s_tag;

    sw_nto1_arb #(.IN_N(N), .IN_W(W), .TAG_W(TW)) u_dut (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .upreq_i  (upreq_i),
        .uptag_i  (uptag_i),
        .uplast_i (uplast_i),
        .uprdy_o  (uprdy_o),
        .dnreq_o  (dnreq_o),
        .dntag_o  (dntag_o),
        .dnlast_o (dnlast_o),
        .dnsrc_o  (dnsrc_o),
        .dnrdy_i  (dnrdy_i)
    );

    sw_nto1_arb #(.IN_N(N5), .IN_W(W), .TAG_W(TW)) u_dut5 (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .upreq_i  (req5),
        .uptag_i  (tag5),
        .uplast_i (last5),
        .uprdy_o  (rdy5),
        .dnreq_o  (dnreq5),
        .dntag_o  (dntag5),
        .dnlast_o (dnlast5),
        .dnsrc_o  (dnsrc5),
        .dnrdy_i  (dnrdy5)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic add(input int s, input logic [TW-1:0] tag, input logic last);
        tab[s][len[s]] = {last, tag};
        len[s]++;
    endtask

    task automatic expb(input int s, input logic [TW-1:0] tag, input logic last);
        beat_t b;
        b.src = W'(s);
        b.tag = tag;
        b.last = last;
        expq.push_back(b);
    endtask

    task automatic clear_src();
        for (int i = 0; i < N; i++) begin
            len[i] = 0;
            ptr[i] = 0;
        end
        hold = '0;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            upreq_i[i] = !hold[i] && (ptr[i] < len[i]);
            {uplast_i[i], uptag_i[i]} = upreq_i[i] ? tab[i][ptr[i] % 8] : '0;
        end
    endtask

    // One clock: present source heads, sample at negedge, score transfers, advance on acceptance.
    task automatic cyc();
        beat_t e;
        logic  viol;
        drive();
        @(negedge clk_i);
        s_rdy = uprdy_o;
        s_req = dnreq_o;
        s_src = dnsrc_o;
        s_tag = dntag_o;
        s5_src = dnsrc5;
        s5_rdy = rdy5;
        s_xfer = rst_n_i && dnreq_o && dnrdy_i;
        acc = upreq_i & uprdy_o;
        if (rst_n_i) begin
            viol = 1'b0;
            for (int i = 0; i < N; i++)
                if (pend[i] && (!upreq_i[i] || uptag_i[i] != pend_tag[i])) viol = 1'b1;
            chk("proto_stable", 32'(viol), 0);
            if (s_xfer) begin
                chk("beat_avail", 32'(expq.size() != 0), 1);
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    chk("beat_src", 32'(dnsrc_o), 32'(e.src));
                    chk("beat_tag", 32'(dntag_o), 32'(e.tag));
                    chk("beat_last", 32'(dnlast_o), 32'(e.last));
                end
            end
            pend = upreq_i & ~acc;
            for (int i = 0; i < N; i++) pend_tag[i] = uptag_i[i];
        end else begin
            pend = '0;
        end
        @(posedge clk_i);
        #1;
        for (int i = 0; i < N; i++) if (acc[i]) ptr[i]++;
    endtask

    initial begin
        clear_src();
        pend = '0;
        acc = '0;

        // reset with every source requesting, then single-beat rotation
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < N; s++) begin
                add(s, TW'(r * 8 + s), 1'b1);
                expb(s, TW'(r * 8 + s), 1'b1);
            end
        repeat (3) begin
            cyc();
            chk("rst_rdy", 32'(s_rdy), 0);
            chk("rst_state", 32'(u_dut.state_q), 32'(ARB));
        end
        rst_n_i = 1'b1;
        cyc();
        chk("first_gnt", 32'(s_src), 0);
        chk("first_xfer", 32'(s_xfer), 1);
        for (int k = 1; k < 2 * N; k++) begin
            cyc();
            chk("rr_xfer", 32'(s_xfer), 1);
        end
        chk("rr_drain", 32'(expq.size()), 0);

        // lock: src2 four beats while src0 and src5 wait
        clear_src();
        add(1, 4'h1, 1'b1);
        expb(1, 4'h1, 1'b1);
        cyc();
        chk("lock_pre", 32'(s_src), 1);
        clear_src();
        add(2, 4'hA, 1'b0); add(2, 4'hB, 1'b0); add(2, 4'hC, 1'b0); add(2, 4'hD, 1'b1);
        add(0, 4'h0, 1'b1);
        add(5, 4'h5, 1'b1);
        expb(2, 4'hA, 1'b0); expb(2, 4'hB, 1'b0); expb(2, 4'hC, 1'b0); expb(2, 4'hD, 1'b1);
        expb(5, 4'h5, 1'b1);
        expb(0, 4'h0, 1'b1);
        repeat (4) begin
            cyc();
            chk("lock_src", 32'(s_src), 2);
            chk("lock_rdy", 32'(s_rdy), 32'h04);
        end
        cyc();
        chk("lock_next", 32'(s_src), 5);
        cyc();
        chk("lock_then", 32'(s_src), 0);
        chk("lock_drain", 32'(expq.size()), 0);

        // lock bubble and downstream backpressure on src3
        clear_src();
        add(3, 4'h6, 1'b0); add(3, 4'h7, 1'b0); add(3, 4'h8, 1'b1);
        add(0, 4'h0, 1'b1);
        add(4, 4'h4, 1'b1);
        expb(3, 4'h6, 1'b0); expb(3, 4'h7, 1'b0); expb(3, 4'h8, 1'b1);
        expb(4, 4'h4, 1'b1);
        expb(0, 4'h0, 1'b1);
        cyc();
        chk("bub_first", 32'(s_src), 3);
        hold[3] = 1'b1;
        repeat (2) begin
            cyc();
            chk("bub_req", 32'(s_req), 0);
            chk("bub_rdy", 32'(s_rdy), 0);
        end
        hold[3] = 1'b0;
        dnrdy_i = 1'b0;
        repeat (3) begin
            cyc();
            chk("bp_req", 32'(s_req), 1);
            chk("bp_src", 32'(s_src), 3);
            chk("bp_tag", 32'(s_tag), 32'h7);
            chk("bp_rdy", 32'(s_rdy), 0);
        end
        dnrdy_i = 1'b1;
        repeat (2) begin
            cyc();
            chk("bub_tail", 32'(s_src), 3);
        end
        cyc();
        chk("bub_next", 32'(s_src), 4);
        cyc();
        chk("bub_drain", 32'(expq.size()), 0);

        // async reset in the middle of a src6 packet
        clear_src();
        add(6, 4'h9, 1'b0); add(6, 4'hA, 1'b0); add(6, 4'hB, 1'b1);
        expb(6, 4'h9, 1'b0);
        cyc();
        chk("ar_beat1", 32'(s_src), 6);
        drive();
        #1;
        chk("ar_pre_rdy", 32'(uprdy_o), 32'h40);
        rst_n_i = 1'b0;
        #1;
        chk("ar_rst_rdy", 32'(uprdy_o), 0);
        chk("ar_rst_state", 32'(u_dut.state_q), 32'(ARB));
        clear_src();
        repeat (2) cyc();
        rst_n_i = 1'b1;
        add(0, 4'h1, 1'b1);
        add(6, 4'h2, 1'b1);
        expb(0, 4'h1, 1'b1);
        expb(6, 4'h2, 1'b1);
        cyc();
        chk("ar_post_gnt", 32'(s_src), 0);
        cyc();
        chk("ar_post_next", 32'(s_src), 6);
        chk("ar_drain", 32'(expq.size()), 0);

        // five sources: move rr_ptr to 4, then wrap from 4 to 1
        last5 = '1;
        req5 = 5'b01000;
        cyc();
        chk("w5_setup", 32'(s5_src), 3);
        req5 = 5'b10010;
        cyc();
        chk("w5_first", 32'(s5_src), 4);
        chk("w5_first_rdy", 32'(s5_rdy), 32'h10);
        req5 = 5'b00010;
        cyc();
        chk("w5_second", 32'(s5_src), 1);
        chk("w5_ptr", 32'(u_dut5.rr_ptr_q), 2);
        req5 = 5'b00101;
        cyc();
        chk("w5_after", 32'(s5_src), 2);
        req5 = '0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
